// File: rtl/alu_mdu_if.sv
// Request/response bundle between the ALU/MDU and its requester.
// The requester side is master; the execution unit is slave.
interface alu_mdu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_mdu.sv
// Integer ALU plus iterative multiply/divide unit (shift-add multiply, restoring divide).
// Single-cycle ops and divide corner cases finish at accept; other M ops iterate XLEN cycles.
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_mdu_if.slave    bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opd;
    logic [2:0]        r_op;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_last;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_int_res;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_dshift;
    logic [XLEN:0]     w_ddiff;
    logic              w_dfit;
    logic [XLEN-1:0]   w_iter_hi;
    logic [XLEN-1:0]   w_iter_lo;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_slow_res;

    assign w_accept      = bus.in_valid && (r_state == S_IDLE);
    assign w_last        = (r_cnt == CW'(XLEN - 1));
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_BUSY);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = (r_result == '0);

    // Integer operations, decoded straight from the request at accept time
    assign w_shamt = bus.b[SHW-1:0];
    always_comb begin
        w_int_res = '0;
        case (bus.op[3:0])
            4'b0000: w_int_res = bus.a + bus.b;
            4'b1000: w_int_res = bus.a - bus.b;
            4'b0001: w_int_res = bus.a << w_shamt;
            4'b0010: w_int_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            4'b0011: w_int_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            4'b0100: w_int_res = bus.a ^ bus.b;
            4'b0101: w_int_res = bus.a >> w_shamt;
            4'b1101: w_int_res = $unsigned($signed(bus.a) >>> w_shamt);
            4'b0110: w_int_res = bus.a | bus.b;
            4'b0111: w_int_res = bus.a & bus.b;
            default: w_int_res = '0;
        endcase
    end

    // Divide corner cases resolve immediately instead of iterating
    assign w_div_zero = (bus.b == '0);
    assign w_div_ovf  = !bus.op[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    assign w_fast     = !bus.op[4] || (bus.op[2] && (w_div_zero || w_div_ovf));
    assign w_fast_res = !bus.op[4] ? w_int_res :
                        w_div_zero ? (bus.op[1] ? bus.a : '1) :
                                     (bus.op[1] ? '0 : bus.a);

    // Signed M ops run on magnitudes; signs are restored on the final step
    assign w_a_signed = (bus.op[2:0] == 3'b001) || (bus.op[2:0] == 3'b010) ||
                        (bus.op[2:0] == 3'b100) || (bus.op[2:0] == 3'b110);
    assign w_b_signed = (bus.op[2:0] == 3'b001) || (bus.op[2:0] == 3'b100) ||
                        (bus.op[2:0] == 3'b110);
    assign w_a_neg    = w_a_signed && bus.a[XLEN-1];
    assign w_b_neg    = w_b_signed && bus.b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag    = w_b_neg ? -bus.b : bus.b;

    assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    assign w_dshift = {r_hi, r_lo[XLEN-1]};
    assign w_ddiff  = w_dshift - {1'b0, r_opd};
    assign w_dfit   = !w_ddiff[XLEN];

    assign w_iter_hi = r_op[2] ? (w_dfit ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0])
                               : w_msum[XLEN:1];
    assign w_iter_lo = r_op[2] ? {r_lo[XLEN-2:0], w_dfit}
                               : {w_msum[0], r_lo[XLEN-1:1]};

    assign w_prod_s = r_neg_res ? -{w_iter_hi, w_iter_lo} : {w_iter_hi, w_iter_lo};
    always_comb begin
        w_slow_res = '0;
        case (r_op)
            3'b000:                 w_slow_res = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_slow_res = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_slow_res = r_neg_res ? -w_iter_lo : w_iter_lo;
            default:                w_slow_res = r_neg_rem ? -w_iter_hi : w_iter_hi;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_state_next = w_fast ? S_DONE : S_BUSY;
            S_BUSY: if (w_last)       w_state_next = S_DONE;
            S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opd     <= '0;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else if (w_accept) begin
            if (w_fast) begin
                r_result <= w_fast_res;
            end else begin
                r_cnt     <= '0;
                r_hi      <= '0;
                r_lo      <= bus.op[2] ? w_a_mag : w_b_mag;
                r_opd     <= bus.op[2] ? w_b_mag : w_a_mag;
                r_op      <= bus.op[2:0];
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
            end
        end else if (r_state == S_BUSY) begin
            r_hi  <= w_iter_hi;
            r_lo  <= w_iter_lo;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_result <= w_slow_res;
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at XLEN=32: latency, results, backpressure and reset abort.
module tb_alu_mdu;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_mdu_if #(.XLEN(32)) bus ();

    alu_mdu #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns just after the handshake edge.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int exp_busy);
        int lat;
        int nbusy;
        chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 5'($urandom());
        bus.a        = $urandom();
        bus.b        = $urandom();
        lat   = 1;
        nbusy = 0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.busy) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(bus.result), 64'(exp_res));
        chk({tag, "_zero"}, 64'(bus.zero), 64'(exp_res == 32'd0));
        if (exp_busy > 0) chk({tag, "_busy"}, 64'(nbusy), 64'(exp_busy));
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
        $display("op %s a=%h b=%h result=%h latency=%0d", tag, a, b, exp_res, lat);
    endtask

    initial begin
        int seen;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 64'({bus.out_valid, bus.busy, bus.in_ready, bus.zero}), 64'b0011);
        chk("reset_res", 64'(bus.result), 64'd0);
        rst_n = 1'b1;

        do_op("add",    5'b00000, 32'd5,        32'd7,        32'h0000000C, 1, 0);
        do_op("sub",    5'b01000, 32'd7,        32'd7,        32'h00000000, 1, 0);
        do_op("sra",    5'b01101, 32'h80000000, 32'h24,       32'hF8000000, 1, 0);
        do_op("srl",    5'b00101, 32'h80000000, 32'h24,       32'h08000000, 1, 0);
        do_op("sll",    5'b00001, 32'h1,        32'h21,       32'h00000002, 1, 0);
        do_op("slt",    5'b00010, 32'hFFFFFFFF, 32'h1,        32'h00000001, 1, 0);
        do_op("sltu",   5'b00011, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1, 0);
        do_op("xor",    5'b00100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1, 0);
        do_op("or",     5'b00110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1, 0);
        do_op("and",    5'b00111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1, 0);
        do_op("badop",  5'b01001, 32'h12345678, 32'h1,        32'h00000000, 1, 0);
        do_op("mulh",   5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 32);
        do_op("mulhu",  5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32);
        do_op("mul",    5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 32);
        do_op("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 33, 32);
        do_op("div",    5'b10100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33, 32);
        do_op("rem",    5'b10110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33, 32);
        do_op("divu",   5'b10101, 32'hFFFFFFF9, 32'h2,        32'h7FFFFFFC, 33, 32);
        do_op("remu",   5'b10111, 32'hFFFFFFF9, 32'h2,        32'h00000001, 33, 32);
        do_op("div_nd", 5'b10100, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 32);
        do_op("rem_nd", 5'b10110, 32'h7,        32'hFFFFFFFE, 32'h00000001, 33, 32);
        do_op("div_op3",5'b11100, 32'd100,      32'd7,        32'h0000000E, 33, 32);
        do_op("divu0",  5'b10101, 32'h1234,     32'h0,        32'hFFFFFFFF, 1, 0);
        do_op("remu0",  5'b10111, 32'h1234,     32'h0,        32'h00001234, 1, 0);
        do_op("div_ov", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        do_op("rem_ov", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);

        // Backpressure: result held while out_ready is low, no accept until after handshake
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 5'b00000;
        bus.a         = 32'd1;
        bus.b         = 32'd2;
        @(posedge clk);
        #1;
        bus.op = 5'b01000;
        bus.a  = 32'd9;
        bus.b  = 32'd4;
        chk("bp_first", 64'({bus.out_valid, bus.result}), {31'd0, 1'b1, 32'd3});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", 64'({bus.out_valid, bus.in_ready, bus.result}), {30'd0, 2'b10, 32'd3});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_handshake", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_next", 64'({bus.out_valid, bus.result}), {31'd0, 1'b1, 32'd5});
        @(posedge clk);
        #1;
        chk("bp_idle", 64'(bus.in_ready), 64'd1);
        $display("op backpressure add then sub result=%h", 32'd5);

        // Reset pulse in the middle of a divide, with a competing request held during BUSY
        bus.in_valid = 1'b1;
        bus.op       = 5'b10100;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        @(posedge clk);
        #1;
        bus.op = 5'b00000;
        bus.a  = 32'd1;
        bus.b  = 32'd1;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_ignore", 64'({bus.busy, bus.in_ready, bus.out_valid}), 64'b100);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 64'({bus.out_valid, bus.busy, bus.in_ready, bus.zero}), 64'b0011);
        chk("rst_mid_res", 64'(bus.result), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || bus.busy) seen++;
        end
        chk("rst_abandon", 64'(seen), 64'd0);
        $display("op reset mid-divide abandoned seen=%0d", seen);
        do_op("add_post", 5'b00000, 32'h10, 32'h20, 32'h00000030, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; legal values 32 or 64.
REQ-002 Parameter SHW, default $clog2(XLEN): shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  5  operation select (REQ-012, REQ-013).
REQ-008 a  input  XLEN  operand A (rs1).
REQ-009 b  input  XLEN  operand B (rs2 or immediate).
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-011a result  output  XLEN  operation result; zero  output  1  result == 0; busy  output  1  iterative operation in progress.

Function
REQ-012 op[4]=0, integer op on op[3:0]: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111; any other code gives result 0.
REQ-013 op[4]=1, M op on op[2:0] (op[3] ignored): MUL 000 (low XLEN), MULH 001 (s x s, high), MULHSU 010 (s x u, high), MULHU 011 (u x u, high), DIV 100, DIVU 101, REM 110, REMU 111.
REQ-014 Shifts use b[SHW-1:0] only; SRA sign-fills; SLT/SLTU give 1 or 0, zero-extended.
REQ-015 ADD/SUB/MUL wrap modulo 2^XLEN; no overflow or carry flag.
REQ-016 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; busy = 1 only in BUSY.
REQ-017 Accept = in_valid && in_ready; a, b and op are captured at accept; later changes on the inputs are ignored.
REQ-018 Integer op, divide by zero, or signed-overflow divide: IDLE -> DONE at the accept edge; out_valid is high in the next cycle (1-cycle latency).
REQ-019 Other M ops: IDLE -> BUSY at accept; 1 iteration per cycle (shift-add multiply, restoring divide on magnitudes, sign fix-up at the end); BUSY lasts exactly XLEN cycles, then -> DONE; out_valid rises XLEN+1 cycles after the accept edge.
REQ-020 Divide by zero: DIV/DIVU give all-ones; REM/REMU give a.
REQ-021 DIV with a = most-negative and b = -1 gives a; REM gives 0.
REQ-022 Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-023 DONE: out_valid = 1; result and zero stay stable until out_valid && out_ready; at that handshake go DONE -> IDLE; no accept in the same cycle.
REQ-024 Result is registered; zero is derived from the registered result; outputs do not depend combinationally on a, b or op.
REQ-025 In_valid while not IDLE is ignored without loss of the current operation; the requester holds the request.
REQ-026 Iteration counter width is $clog2(XLEN)+1; it has no wrap-around hazard at XLEN=64.

Reset
REQ-027 rst_n low forces, asynchronously: state IDLE, out_valid 0, busy 0, result 0, zero 1, counter 0, operand registers 0.
REQ-028 Reset during BUSY or DONE abandons the operation; no out_valid appears after release.
REQ-029 First accept is possible in the first cycle after rst_n deasserts; in_ready = 1 in that cycle.

Verification
REQ-030 ADD a=5, b=7, out_ready=1 -> result 0x0000000C, zero 0, out_valid exactly 1 cycle after accept; SUB 7-7 -> 0, zero 1; SRA 0x80000000 by b=0x24 -> 0xF8000000 (shift 4).
REQ-031 MULH a=b=0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL -> 0x00000001; each with out_valid exactly 33 cycles after accept and busy high for 32 cycles.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-033 DIVU 0x1234 / 0 -> 0xFFFFFFFF and REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; all with 1-cycle latency.
REQ-034 out_ready low for 5 cycles in DONE -> result and out_valid held; in_ready 0; a new in_valid is not accepted until the cycle after the handshake.
REQ-035 rst_n pulsed low for 1 cycle mid-BUSY on a DIV -> all outputs at reset values immediately; no out_valid afterwards; next ADD completes normally.
